scan_decoder: RTL and testbench



---
 rtl/scan_decoder_pkg.sv | 32 +++
 rtl/scan_decoder_if.sv | 27 ++
 rtl/scan_decoder_core.sv | 21 ++
 rtl/scan_decoder.sv | 151 +++++++++++++++
 tb/tb_scan_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and elaboration helpers for the scan decoder: FSM state encoding,
// output-width and counter-width helpers, and the scan-length clamp.
package scan_decoder_pkg;

  localparam int MAX_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic int n_out(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int cnt_w(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // A length of zero or anything past the last output means "scan every line".
  function automatic logic [MAX_ADDR_W:0] clamp_len(input logic [MAX_ADDR_W:0] raw,
                                                     input int addr_w);
    logic [MAX_ADDR_W:0] full;
    full = (MAX_ADDR_W + 1)'(n_out(addr_w));
    return (raw == '0 || raw > full) ? full : raw;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control and select bundle between a scan_decoder and whatever drives it.
interface scan_decoder_if
  import scan_decoder_pkg::*;
#(
  parameter int ADDR_W = 3
);
  logic                        g1;
  logic                        g2a_n;
  logic                        g2b_n;
  logic                        mode;
  logic [ADDR_W-1:0]           addr;
  logic [ADDR_W:0]             scan_len;
  logic [n_out(ADDR_W)-1:0]    y;
  logic [ADDR_W-1:0]           cur_addr;
  logic                        step;
  logic                        wrap;

  modport master (
    output g1, g2a_n, g2b_n, mode, addr, scan_len,
    input  y, cur_addr, step, wrap
  );

  modport slave (
    input  g1, g2a_n, g2b_n, mode, addr, scan_len,
    output y, cur_addr, step, wrap
  );
endinterface

// File: rtl/scan_decoder_core.sv
// Combinational ADDR_W-to-N_OUT line decode with selectable output polarity.
module scan_decoder_core
  import scan_decoder_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [ADDR_W-1:0]        addr,
  output logic [n_out(ADDR_W)-1:0] y
);
  localparam int N_OUT = n_out(ADDR_W);

  logic [N_OUT-1:0] onehot;

  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

  assign y = ACTIVE_LOW ? ~onehot : onehot;
endmodule

// File: rtl/scan_decoder.sv
// 74LS138-style decoder with registered outputs and an auto-scan sequencer
// that dwells on each position and optionally blanks between positions.
//
// state     | meaning
// ST_IDLE   | disabled, outputs inactive, scan position cleared
// ST_DIRECT | outputs follow the addr input each cycle
// ST_DRIVE  | scan position driven, dwell timer running
// ST_GAP    | all outputs inactive between scan positions
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int N_OUT = n_out(ADDR_W);
  localparam int CNT_W = cnt_w(DWELL, BLANK);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [N_OUT-1:0] INACTIVE = {N_OUT{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [N_OUT-1:0]  y_q, y_d;

  logic              en;
  logic              advance;
  logic              last_pos;
  logic [LEN_W-1:0]  len_new;
  logic [ADDR_W-1:0] nidx;
  logic [ADDR_W-1:0] dec_addr;
  logic [N_OUT-1:0]  dec_y;

  assign en       = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
  assign len_new  = LEN_W'(clamp_len((MAX_ADDR_W + 1)'(bus.scan_len), ADDR_W));
  assign last_pos = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign nidx     = last_pos ? '0 : idx_q + ADDR_W'(1);

  scan_decoder_core #(
    .ADDR_W     (ADDR_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .addr (dec_addr),
    .y    (dec_y)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cur_d    = cur_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    y_d      = INACTIVE;
    dec_addr = idx_q;
    advance  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!bus.mode) begin
      state_d  = ST_DIRECT;
      dec_addr = bus.addr;
      y_d      = dec_y;
      cur_d    = bus.addr;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          state_d  = ST_DRIVE;
          idx_d    = '0;
          len_d    = len_new;
          cnt_d    = DWELL_LD;
          dec_addr = '0;
          y_d      = dec_y;
          cur_d    = '0;
          step_d   = 1'b1;
          wrap_d   = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            y_d   = dec_y;
          end else if (BLANK > 0) begin
            state_d = ST_GAP;
            cnt_d   = BLANK_LD;
          end else begin
            advance = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             advance = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      // The scan length only takes effect at a frame boundary.
      if (advance) begin
        state_d  = ST_DRIVE;
        idx_d    = nidx;
        cnt_d    = DWELL_LD;
        dec_addr = nidx;
        y_d      = dec_y;
        cur_d    = nidx;
        step_d   = 1'b1;
        wrap_d   = (nidx == '0);
        if (nidx == '0) len_d = len_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cur_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= INACTIVE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.cur_addr = cur_q;
  assign bus.step     = step_q;
  assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Drives two scan_decoder builds (blanking/one-cold and no-blank/one-hot) with the
// same stimulus and compares both against a cycle-count based reference model.
module tb_scan_decoder;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  scan_decoder_if #(.ADDR_W(3)) ifa ();
  scan_decoder_if #(.ADDR_W(3)) ifb ();

  scan_decoder #(.ADDR_W(3), .DWELL(DWELL), .BLANK(1), .ACTIVE_LOW(1'b1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  scan_decoder #(.ADDR_W(3), .DWELL(DWELL), .BLANK(0), .ACTIVE_LOW(1'b0)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  always #5 clk = ~clk;

  // Reference: a scan is "cycle t of period DWELL+BLANK at position pos".
  bit         m_scan [2];
  int         m_t    [2];
  int         m_pos  [2];
  int         m_len  [2];
  logic [7:0] exp_y    [2];
  logic [2:0] exp_cur  [2];
  logic       exp_step [2];
  logic       exp_wrap [2];

  function automatic int blank_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [7:0] inact(input int i);
    return (i == 0) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] dec(input int i, input int p);
    logic [7:0] v;
    v = 8'd1 << p;
    return (i == 0) ? ~v : v;
  endfunction

  function automatic int clampl(input int sl);
    return (sl == 0 || sl > 8) ? 8 : sl;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 1'b0; m_t[i] = 0; m_pos[i] = 0; m_len[i] = 0;
      exp_y[i] = inact(i); exp_cur[i] = 3'd0; exp_step[i] = 1'b0; exp_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit en, input bit md, input int a, input int sl);
    for (int i = 0; i < 2; i++) begin
      exp_step[i] = 1'b0;
      exp_wrap[i] = 1'b0;
      if (!en) begin
        m_scan[i] = 1'b0;
        exp_y[i]  = inact(i);
      end else if (!md) begin
        m_scan[i]  = 1'b0;
        exp_y[i]   = dec(i, a);
        exp_cur[i] = 3'(a);
      end else begin
        if (!m_scan[i]) begin
          m_scan[i] = 1'b1; m_pos[i] = 0; m_t[i] = 0; m_len[i] = clampl(sl);
        end else begin
          m_t[i]++;
          if (m_t[i] == DWELL + blank_of(i)) begin
            m_t[i]   = 0;
            m_pos[i] = (m_pos[i] + 1 >= m_len[i]) ? 0 : m_pos[i] + 1;
            if (m_pos[i] == 0) m_len[i] = clampl(sl);
          end
        end
        exp_y[i]    = (m_t[i] < DWELL) ? dec(i, m_pos[i]) : inact(i);
        exp_cur[i]  = 3'(m_pos[i]);
        exp_step[i] = (m_t[i] == 0);
        exp_wrap[i] = (m_t[i] == 0) && (m_pos[i] == 0);
      end
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] oy;
    logic [2:0] oc;
    logic       os, ow;
    for (int i = 0; i < 2; i++) begin
      oy = (i == 0) ? ifa.y        : ifb.y;
      oc = (i == 0) ? ifa.cur_addr : ifb.cur_addr;
      os = (i == 0) ? ifa.step     : ifb.step;
      ow = (i == 0) ? ifa.wrap     : ifb.wrap;
      checks++;
      assert (oy === exp_y[i]) else begin
        failures++;
        $error("FAIL %s y dut%0d observed=%h expected=%h", tag, i, oy, exp_y[i]);
      end
      checks++;
      assert (oc === exp_cur[i]) else begin
        failures++;
        $error("FAIL %s cur_addr dut%0d observed=%0d expected=%0d", tag, i, oc, exp_cur[i]);
      end
      checks++;
      assert (os === exp_step[i]) else begin
        failures++;
        $error("FAIL %s step dut%0d observed=%b expected=%b", tag, i, os, exp_step[i]);
      end
      checks++;
      assert (ow === exp_wrap[i]) else begin
        failures++;
        $error("FAIL %s wrap dut%0d observed=%b expected=%b", tag, i, ow, exp_wrap[i]);
      end
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int g1, input int g2a, input int g2b, input int md,
                       input int a, input int sl);
    ifa.g1 = 1'(g1); ifa.g2a_n = 1'(g2a); ifa.g2b_n = 1'(g2b);
    ifa.mode = 1'(md); ifa.addr = 3'(a); ifa.scan_len = 4'(sl);
    ifb.g1 = 1'(g1); ifb.g2a_n = 1'(g2a); ifb.g2b_n = 1'(g2b);
    ifb.mode = 1'(md); ifb.addr = 3'(a); ifb.scan_len = 4'(sl);
  endtask

  task automatic cyc(input int g1, input int g2a, input int g2b, input int md,
                     input int a, input int sl, input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    drive(g1, g2a, g2b, md, a, sl);
    model_edge(g1 == 1 && g2a == 0 && g2b == 0, md != 0, a, sl);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic bound_fail(input string tag, input bit found);
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s wait bound expired observed=0 expected=1", tag);
    end
  endtask

  initial begin
    bit found;
    int rg1, rg2a, rg2b, rmd, rsl;

    rst_n = 1'b0;
    drive(0, 1, 1, 0, 0, 0);
    #12;
    model_reset();
    check("reset");

    cyc(1, 0, 0, 0, 5, 0, "direct5");
    expect8("direct5_pattern", ifa.y, 8'hDF);
    cyc(1, 0, 0, 0, 6, 0, "direct6");
    cyc(0, 0, 0, 0, 2, 0, "dis_g1");
    expect8("dis_g1_pattern", ifa.y, 8'hFF);
    cyc(1, 0, 0, 0, 2, 0, "direct2a");
    cyc(1, 1, 0, 0, 2, 0, "dis_g2a");
    expect8("dis_g2a_pattern", ifa.y, 8'hFF);
    cyc(1, 0, 0, 0, 2, 0, "direct2b");
    cyc(1, 0, 1, 0, 2, 0, "dis_g2b");
    expect8("dis_g2b_pattern", ifa.y, 8'hFF);

    for (int k = 0; k < 35; k++) begin
      cyc(1, 0, 0, 1, 0, 3, "scan3");
      if (k == 0) expect8("scan3_first", ifa.y, 8'hFE);
      if (k == 5) expect8("scan3_pos1", ifa.y, 8'hFD);
    end

    // Change the length mid-frame; the running frame must still stop at position 2.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_pos[0] == 1) found = 1'b1;
      else cyc(1, 0, 0, 1, 0, 3, "scan3_seek");
    end
    bound_fail("seek_pos1", found);
    for (int k = 0; k < 60; k++) cyc(1, 0, 0, 1, 0, 8, "scan8");
    for (int k = 0; k < 50; k++) cyc(1, 0, 0, 1, 0, 0, "scan0");

    cyc(1, 0, 0, 0, 3, 0, "mode_to_direct");
    cyc(1, 0, 0, 1, 0, 5, "rescan");
    expect8("rescan_pattern", ifa.y, 8'hFE);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_pos[0] == 1 && m_t[0] < DWELL) found = 1'b1;
      else cyc(1, 0, 0, 1, 0, 5, "drive_seek");
    end
    bound_fail("seek_drive1", found);
    cyc(0, 0, 0, 1, 0, 5, "drop_g1");
    expect8("drop_g1_pattern", ifa.y, 8'hFF);
    cyc(1, 0, 0, 1, 0, 5, "reenable");
    expect8("reenable_pattern", ifa.y, 8'hFE);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_t[0] == DWELL) found = 1'b1;
      else cyc(1, 0, 0, 1, 0, 5, "gap_seek");
    end
    bound_fail("seek_gap", found);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_mid_gap");
    expect8("reset_mid_gap_pattern", ifa.y, 8'hFF);

    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 1, 0, 1, "len1");
      expect8("len1_onehot", ifb.y, 8'h01);
    end

    rg1 = 1; rg2a = 0; rg2b = 0; rmd = 1; rsl = 3;
    for (int k = 0; k < 600; k++) begin
      rg1  = ($urandom_range(0, 24) == 0) ? 0 : 1;
      rg2a = ($urandom_range(0, 39) == 0) ? 1 : 0;
      rg2b = ($urandom_range(0, 39) == 0) ? 1 : 0;
      if ($urandom_range(0, 29) == 0) rmd = 1 - rmd;
      if ($urandom_range(0, 9) == 0) rsl = $urandom_range(0, 15);
      cyc(rg1, rg2a, rg2b, rmd, $urandom_range(0, 7), rsl, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
